// File: rtl/instr_fetch_sequencer.sv
// Two-phase byte fetch into a 16-bit IR: LSB at PC, MSB at PC+1,
// then holds the instruction until the decode stage takes it.
module instr_fetch_sequencer #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Halt,
    output logic                  MemRead,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    input  logic [7:0]            MemData,
    input  logic                  MemAck,
    output logic                  IRWrite,
    output logic                  IRLH,
    output logic [7:0]            IRData,
    output logic                  InstrValid,
    input  logic                  InstrReady,
    output logic [ADDR_WIDTH-1:0] InstrPC,
    input  logic                  PCLoad,
    input  logic [ADDR_WIDTH-1:0] PCIn
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH_L,
        FETCH_H,
        HOLD
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic [ADDR_WIDTH-1:0] pc_inc;

    assign pc_inc     = pc + ADDR_WIDTH'(1);

    assign MemRead    = (state == FETCH_L) || (state == FETCH_H);
    assign MemAddr    = pc;
    assign IRLH       = (state == FETCH_H);
    assign InstrValid = (state == HOLD);
    assign InstrPC    = instr_pc;
    assign IRData     = MemData;

    // A redirect kills the byte in flight so the IR never sees it.
    assign IRWrite    = MemAck & MemRead & ~PCLoad;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            instr_pc <= RESET_PC;
        end else if (PCLoad) begin
            pc    <= PCIn;
            state <= Halt ? IDLE : FETCH_L;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!Halt) state <= FETCH_L;
                end
                FETCH_L: begin
                    if (MemAck) begin
                        instr_pc <= pc;
                        pc       <= pc_inc;
                        state    <= FETCH_H;
                    end
                end
                FETCH_H: begin
                    if (MemAck) begin
                        pc    <= pc_inc;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (InstrReady) state <= Halt ? IDLE : FETCH_L;
                end
            endcase
        end
    end

endmodule
